ex_mem_pipe: RTL
================

# ex_mem_pipe

EX→MEM pipeline register and miss-stall controller of the MIPS pipeline. It latches the EX stage's result and control bundle, drives the MEM stage's cache request, and freezes the front of the pipeline while the cache reports a miss. It also keeps a stall-cycle counter and a sticky timeout flag for debug.

## Interface
- MISS_TIMEOUT, 64, consecutive stall cycles after which `miss_timeout` sets (≥2)
- clk  in  1  pipeline clock, all state updates on posedge
- rst_b  in  1  asynchronous active-low reset
- ex_valid  in  1  EX slot holds a real instruction
- ex_alu_result  in  32  ALU result / effective address
- ex_rt_data  in  32  store data (rt register)
- ex_dest_reg  in  5  write-back register index
- ex_reg_write  in  1  instruction writes the register file
- ex_mem_read  in  1  load
- ex_mem_write  in  1  store
- ex_mem_to_reg  in  1  write-back selects memory data
- ex_is_LB_SB  in  1  byte access (LB/SB)
- flush  in  1  replace the next captured EX bundle with a bubble
- hit  in  1  cache hit from MEM stage, same cycle as request
- mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_is_LB_SB  out  1 each  registered copies
- mem_alu_result, mem_rt_data  out  32 each  registered copies
- mem_dest_reg  out  5  registered copy
- cache_en  out  1  cache request = mem_valid & (mem_mem_read | mem_mem_write)
- stall  out  1  freeze PC, IF/ID, ID/EX
- miss_count  out  32  total stalled cycles since reset, saturating
- miss_timeout  out  1  sticky timeout flag

## Operation
- Memory op in MEM slot: `memop = mem_valid & (mem_mem_read | mem_mem_write)`.
- `stall = memop & ~hit`. This is combinational, so it is valid in the same cycle as `hit`.
- Capture: on posedge with stall=0, the register loads the EX bundle. If flush (or a pending flush) is active, it loads a bubble instead: all control bits 0, data fields 0.
- Hold: on posedge with stall=1, every `mem_*` register keeps its value. EX inputs are ignored; upstream holds them because of `stall`.
- Flush during stall: latched into `flush_pend`. It applies at the first capture after the stall releases, then clears. A flush with stall=0 applies immediately.
- Bubbles and non-memory instructions never stall, whatever the value of `hit`.
- The FSM has two states:
  - RUN: stall=0. On posedge with stall=1, go to WAIT and set the consecutive counter `wcnt` to 1.
  - WAIT: each stalled edge increments `wcnt`. On the first edge with stall=0 (the access now hits), return to RUN, clear `wcnt` and capture the next bundle.
- `miss_count` increments on every posedge with stall=1 and saturates at 0xFFFF_FFFF.
- `miss_timeout` sets when `wcnt` reaches MISS_TIMEOUT. It is cleared only by reset.
- `wcnt` is `$clog2(MISS_TIMEOUT)+1` bits wide and saturates at MISS_TIMEOUT.

## Timing
- Reset (async, any state, mid-stall included): all `mem_*` outputs, `miss_count`, `miss_timeout`, `wcnt` and `flush_pend` go to 0; state goes to RUN. Consequently `cache_en`=0 and `stall`=0.
- Latency: EX bundle at edge N appears on `mem_*` after edge N, provided stall=0 at edge N.
- Hit on first try: zero stall cycles, one bundle per cycle.
- Miss for k cycles:
  - stall is high for exactly k cycles;
  - `mem_*` values, including store data, stay stable for all k+1 cycles;
  - the next bundle is captured on the edge where hit=1.
- Store commits on the hit cycle. The register advances on that same edge, so no double write occurs.
- A reset release does not stall: the first cycle always has a bubble in the MEM slot.

## Test plan
- Reset mid-stall with `miss_timeout`=1 and `miss_count`=5: all outputs 0 while rst_b=0, no glitch on release.
- Load at addr 0x0000_0010 with hit=1: `mem_alu_result`=0x10 one cycle later, `cache_en`=1, stall=0, `miss_count`=0.
- Store 0xDEADBEEF with hit=0 for 3 cycles, then 1:
  - stall=1 for exactly 3 cycles;
  - `mem_rt_data` held at 0xDEADBEEF throughout;
  - `miss_count`=3;
  - the next bundle is captured on the hit edge.
- Flush asserted during cycle 2 of a 4-cycle miss: the slot after the release is a bubble (`mem_valid`=0), and the following EX bundle is captured normally.
- ALU-only instruction (reg_write=1, no memory op) with hit=0: no stall, `cache_en`=0.
- MISS_TIMEOUT=4 with hit held low 6 cycles:
  - `miss_timeout` rises after the 4th stalled edge and stays 1 after the hit;
  - `miss_count`=6.

Source files
------------

// File: rtl/ex_mem_pipe_if.sv
// EX->MEM pipeline bundle, MEM-stage cache handshake and debug outputs.
// The pipe register sits on the slave side; the EX stage / bench drives the master side.
interface ex_mem_pipe_if;
  logic        ex_valid;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_rt_data;
  logic [4:0]  ex_dest_reg;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_mem_to_reg;
  logic        ex_is_LB_SB;
  logic        flush;
  logic        hit;

  logic        mem_valid;
  logic        mem_reg_write;
  logic        mem_mem_read;
  logic        mem_mem_write;
  logic        mem_mem_to_reg;
  logic        mem_is_LB_SB;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_rt_data;
  logic [4:0]  mem_dest_reg;
  logic        cache_en;
  logic        stall;
  logic [31:0] miss_count;
  logic        miss_timeout;

  modport master (
    output ex_valid, ex_alu_result, ex_rt_data, ex_dest_reg, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_is_LB_SB, flush, hit,
    input  mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg,
           mem_is_LB_SB, mem_alu_result, mem_rt_data, mem_dest_reg, cache_en,
           stall, miss_count, miss_timeout
  );

  modport slave (
    input  ex_valid, ex_alu_result, ex_rt_data, ex_dest_reg, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_is_LB_SB, flush, hit,
    output mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg,
           mem_is_LB_SB, mem_alu_result, mem_rt_data, mem_dest_reg, cache_en,
           stall, miss_count, miss_timeout
  );
endinterface

// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register with cache-miss stall control, deferred flush,
// saturating stall-cycle counter and sticky miss-timeout flag.
module ex_mem_pipe #(
  parameter int MISS_TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst_b,
  ex_mem_pipe_if.slave  bus
);

  localparam int             WW   = $clog2(MISS_TIMEOUT) + 1;
  localparam logic [WW-1:0]  WMAX = WW'(MISS_TIMEOUT);

  typedef enum logic {S_RUN, S_WAIT} state_e;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        is_lb_sb;
    logic [4:0]  dest_reg;
    logic [31:0] alu_result;
    logic [31:0] rt_data;
  } bundle_t;

  state_e        state_q;
  bundle_t       slot_q;
  bundle_t       ex_b;
  logic [WW-1:0] wcnt_q;
  logic [WW-1:0] wcnt_d;
  logic [31:0]   miss_count_q;
  logic          timeout_q;
  logic          flush_pend_q;
  logic          memop;
  logic          stall;

  always_comb begin
    ex_b            = '0;
    ex_b.valid      = bus.ex_valid;
    ex_b.reg_write  = bus.ex_reg_write;
    ex_b.mem_read   = bus.ex_mem_read;
    ex_b.mem_write  = bus.ex_mem_write;
    ex_b.mem_to_reg = bus.ex_mem_to_reg;
    ex_b.is_lb_sb   = bus.ex_is_LB_SB;
    ex_b.dest_reg   = bus.ex_dest_reg;
    ex_b.alu_result = bus.ex_alu_result;
    ex_b.rt_data    = bus.ex_rt_data;
  end

  // Stall must be combinational on hit so the hit cycle itself releases the pipe.
  assign memop = slot_q.valid & (slot_q.mem_read | slot_q.mem_write);
  assign stall = memop & ~bus.hit;

  // Entering WAIT counts the first stalled edge as 1; afterwards count up and saturate.
  assign wcnt_d = (state_q == S_RUN) ? WW'(1)
                : (wcnt_q == WMAX)   ? WMAX
                :                      wcnt_q + WW'(1);

  // NOTE: every register here is plain state with async reset and non-blocking
  // updates, so all of them read the pre-edge values of one another.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= S_RUN;
      slot_q       <= '0;
      wcnt_q       <= '0;
      miss_count_q <= '0;
      timeout_q    <= 1'b0;
      flush_pend_q <= 1'b0;
    end else if (stall) begin
      state_q      <= S_WAIT;
      wcnt_q       <= wcnt_d;
      flush_pend_q <= flush_pend_q | bus.flush;
      if (miss_count_q != 32'hFFFF_FFFF) miss_count_q <= miss_count_q + 32'd1;
      if (wcnt_d == WMAX) timeout_q <= 1'b1;
    end else begin
      // Hit edge (or no memory op): advance, honouring a flush held over the stall.
      state_q      <= S_RUN;
      wcnt_q       <= '0;
      flush_pend_q <= 1'b0;
      slot_q       <= (bus.flush | flush_pend_q) ? bundle_t'('0) : ex_b;
    end
  end

  assign bus.mem_valid      = slot_q.valid;
  assign bus.mem_reg_write  = slot_q.reg_write;
  assign bus.mem_mem_read   = slot_q.mem_read;
  assign bus.mem_mem_write  = slot_q.mem_write;
  assign bus.mem_mem_to_reg = slot_q.mem_to_reg;
  assign bus.mem_is_LB_SB   = slot_q.is_lb_sb;
  assign bus.mem_dest_reg   = slot_q.dest_reg;
  assign bus.mem_alu_result = slot_q.alu_result;
  assign bus.mem_rt_data    = slot_q.rt_data;
  assign bus.cache_en       = memop;
  assign bus.stall          = stall;
  assign bus.miss_count     = miss_count_q;
  assign bus.miss_timeout   = timeout_q;

endmodule
